// File: rtl/io_input_conditioner_if.sv
// Board-facing bundle of the input conditioner: raw pins in, conditioned values and pulses out.
// master is the board/consumer side, slave is the conditioner.
interface io_input_conditioner_if;
  logic [7:0] sw_raw;
  logic [2:0] test_raw;
  logic       btnA_raw;
  logic       btnB_raw;
  logic [7:0] IO_input;
  logic [2:0] TEST_input;
  logic       enterA;
  logic       enterB;
  logic       btn_busy;

  modport master (
    output sw_raw, test_raw, btnA_raw, btnB_raw,
    input  IO_input, TEST_input, enterA, enterB, btn_busy
  );

  modport slave (
    input  sw_raw, test_raw, btnA_raw, btnB_raw,
    output IO_input, TEST_input, enterA, enterB, btn_busy
  );
endinterface

// File: rtl/io_input_conditioner.sv
// Two-flop synchroniser plus four debounce channels (sw, test, btnA, btnB) feeding
// per-button press detectors that emit one enter pulse per debounced press.
module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input logic                    clock,
  input logic                    reset,
  io_input_conditioner_if.slave  io
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} btn_state_e;

  logic [12:0]      sync1_q, sync2_q;
  logic [7:0]       chan_sync [4];
  logic [7:0]       stab_q [4];
  logic [7:0]       stab_d [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  btn_state_e       state_q [2];
  btn_state_e       state_d [2];
  logic             enter_q [2];
  logic             enter_d [2];
  logic             rise [2];
  logic             fall [2];
  logic             busy_q, busy_d;

  // Channel 0 = sw, 1 = test, 2 = btnA, 3 = btnB; all zero-extended to a common width.
  assign chan_sync[0] = sync2_q[7:0];
  assign chan_sync[1] = {5'd0, sync2_q[10:8]};
  assign chan_sync[2] = {7'd0, sync2_q[11]};
  assign chan_sync[3] = {7'd0, sync2_q[12]};

  assign io.IO_input   = stab_q[0];
  assign io.TEST_input = stab_q[1][2:0];
  assign io.enterA     = enter_q[0];
  assign io.enterB     = enter_q[1];
  assign io.btn_busy   = busy_q;

  // Debounce counters, stable values and press detection.
  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      stab_d[ch] = stab_q[ch];
      if (chan_sync[ch] == stab_q[ch]) begin
        cnt_d[ch] = {CNT_W{1'b0}};
      end else if (cnt_q[ch] == CNT_MAX) begin
        stab_d[ch] = chan_sync[ch];
        cnt_d[ch]  = {CNT_W{1'b0}};
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
    // Edges are taken on the next stable value so the pulse lines up with the commit edge.
    for (int i = 0; i < 2; i++) begin
      rise[i]    = stab_d[i+2][0] & ~stab_q[i+2][0];
      fall[i]    = ~stab_d[i+2][0] & stab_q[i+2][0];
      enter_d[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            state_d[i] = HELD;
            enter_d[i] = 1'b1;
          end else begin
            state_d[i] = IDLE;
          end
        end
        HELD: begin
          if (fall[i]) begin
            state_d[i] = IDLE;
          end else begin
            state_d[i] = HELD;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
    busy_d = (state_d[0] == HELD) || (state_d[1] == HELD);
  end

  // All state: synchroniser, debounce channels, button FSMs and output flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 13'd0;
      sync2_q <= 13'd0;
      for (int ch = 0; ch < 4; ch++) begin
        stab_q[ch] <= 8'd0;
        cnt_q[ch]  <= {CNT_W{1'b0}};
      end
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        enter_q[i] <= 1'b0;
      end
      busy_q <= 1'b0;
    end else begin
      sync1_q <= {io.btnB_raw, io.btnA_raw, io.test_raw, io.sw_raw};
      sync2_q <= sync1_q;
      for (int ch = 0; ch < 4; ch++) begin
        stab_q[ch] <= stab_d[ch];
        cnt_q[ch]  <= cnt_d[ch];
      end
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        enter_q[i] <= enter_d[i];
      end
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomised and directed bench for io_input_conditioner against a delay-line/window reference model.
module tb_io_input_conditioner;
  localparam int DC = 4;

  logic clock;
  logic reset;
  io_input_conditioner_if bus ();

  io_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: raw -> two-sample delay -> commit after DC consecutive mismatching samples.
  logic [7:0] m_d1 [4];
  logic [7:0] m_d2 [4];
  logic [7:0] m_stab [4];
  int         m_run [4];
  logic       m_enter [2];

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_d1[c] = 8'd0; m_d2[c] = 8'd0; m_stab[c] = 8'd0; m_run[c] = 0;
    end
    m_enter[0] = 1'b0; m_enter[1] = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] sw, input logic [2:0] tst, input logic a, input logic b);
    logic [7:0] rv [4];
    logic [7:0] seen;
    logic       commit;
    rv[0] = sw; rv[1] = {5'd0, tst}; rv[2] = {7'd0, a}; rv[3] = {7'd0, b};
    for (int c = 0; c < 4; c++) begin
      seen = m_d2[c];
      m_d2[c] = m_d1[c];
      m_d1[c] = rv[c];
      commit = 1'b0;
      if (seen == m_stab[c]) m_run[c] = 0;
      else begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] == DC) begin
          m_stab[c] = seen;
          m_run[c]  = 0;
          commit    = 1'b1;
        end
      end
      if (c >= 2) m_enter[c-2] = commit && seen[0];
    end
  endtask

  int         edge_n, n_a, n_b, first_a, first_b, busy_low;
  logic [7:0] io_at_a;
  logic       busy_seen;

  task automatic clear_marks();
    edge_n = 0; n_a = 0; n_b = 0; first_a = -1; first_b = -1;
    busy_low = -1; busy_seen = 1'b0; io_at_a = 8'd0;
  endtask

  // One clock: drive at negedge, model on posedge, compare at the following negedge.
  task automatic tick(input logic [7:0] sw, input logic [2:0] tst, input logic a, input logic b);
    bus.sw_raw = sw; bus.test_raw = tst; bus.btnA_raw = a; bus.btnB_raw = b;
    @(posedge clock);
    model_edge(sw, tst, a, b);
    @(negedge clock);
    check_val("io_input",   bus.IO_input,   m_stab[0]);
    check_val("test_input", bus.TEST_input, m_stab[1][2:0]);
    check_val("enterA",     bus.enterA,     m_enter[0]);
    check_val("enterB",     bus.enterB,     m_enter[1]);
    check_val("btn_busy",   bus.btn_busy,   m_stab[2][0] | m_stab[3][0]);
    edge_n++;
    if (bus.enterA) begin
      n_a++;
      if (first_a < 0) begin first_a = edge_n; io_at_a = bus.IO_input; end
    end
    if (bus.enterB) begin
      n_b++;
      if (first_b < 0) first_b = edge_n;
    end
    if (bus.btn_busy) busy_seen = 1'b1;
    else if (busy_low < 0) busy_low = edge_n;
  endtask

  // Asynchronous reset pulse starting at a negedge, held over two edges.
  task automatic do_reset(input logic [7:0] sw, input logic [2:0] tst, input logic a, input logic b);
    bus.sw_raw = sw; bus.test_raw = tst; bus.btnA_raw = a; bus.btnB_raw = b;
    reset = 1'b1;
    model_clear();
    #1;
    check_val("rst_io",    bus.IO_input,   8'd0);
    check_val("rst_test",  bus.TEST_input, 3'd0);
    check_val("rst_enterA", bus.enterA,    1'b0);
    check_val("rst_enterB", bus.enterB,    1'b0);
    check_val("rst_busy",  bus.btn_busy,   1'b0);
    repeat (2) begin @(posedge clock); @(negedge clock); end
    check_val("rst_hold_io", bus.IO_input, 8'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] r_sw;
    logic [2:0] r_tst;
    logic       ra, rb;
    reset = 1'b1;
    bus.sw_raw = 8'd0; bus.test_raw = 3'd0; bus.btnA_raw = 1'b0; bus.btnB_raw = 1'b0;
    model_clear();
    clear_marks();
    @(negedge clock);

    // Reset with 8'hA5 on the switches: appears on the 6th edge after release.
    do_reset(8'hA5, 3'd0, 1'b0, 1'b0);
    clear_marks();
    repeat (5) tick(8'hA5, 3'd0, 1'b0, 1'b0);
    check_val("a5_early", bus.IO_input, 8'h00);
    tick(8'hA5, 3'd0, 1'b0, 1'b0);
    check_val("a5_edge6", bus.IO_input, 8'hA5);

    // Short press is rejected.
    clear_marks();
    repeat (3) tick(8'hA5, 3'd0, 1'b1, 1'b0);
    repeat (10) tick(8'hA5, 3'd0, 1'b0, 1'b0);
    check_val("glitch_a_pulses", n_a, 0);
    check_val("glitch_a_busy", busy_seen, 1'b0);

    // Long hold: one pulse on edge 6, busy drops 6 edges after release.
    clear_marks();
    repeat (50) tick(8'hA5, 3'd0, 1'b1, 1'b0);
    check_val("hold_a_pulses", n_a, 1);
    check_val("hold_a_edge", first_a, 6);
    clear_marks();
    repeat (10) tick(8'hA5, 3'd0, 1'b0, 1'b0);
    check_val("release_busy_edge", busy_low, 6);
    check_val("release_no_pulse", n_a, 0);

    // Simultaneous A/B presses with a settled operand.
    repeat (10) tick(8'h3C, 3'd5, 1'b0, 1'b0);
    clear_marks();
    repeat (12) tick(8'h3C, 3'd5, 1'b1, 1'b1);
    check_val("both_a_edge", first_a, 6);
    check_val("both_b_edge", first_b, 6);
    check_val("both_io", io_at_a, 8'h3C);
    check_val("both_counts", {n_a[15:0], n_b[15:0]}, {16'd1, 16'd1});
    repeat (10) tick(8'h3C, 3'd5, 1'b0, 1'b0);

    // Bouncing B then a steady level.
    clear_marks();
    tick(8'h3C, 3'd5, 1'b0, 1'b1);
    tick(8'h3C, 3'd5, 1'b0, 1'b0);
    tick(8'h3C, 3'd5, 1'b0, 1'b1);
    tick(8'h3C, 3'd5, 1'b0, 1'b0);
    edge_n = 0;
    repeat (15) tick(8'h3C, 3'd5, 1'b0, 1'b1);
    check_val("bounce_b_pulses", n_b, 1);
    check_val("bounce_b_edge", first_b, 6);
    repeat (10) tick(8'h3C, 3'd5, 1'b0, 1'b0);

    // Reset while A is held mid-count: pulse only after re-debounce.
    clear_marks();
    repeat (3) tick(8'h3C, 3'd5, 1'b1, 1'b0);
    check_val("prerst_pulses", n_a, 0);
    do_reset(8'h3C, 3'd5, 1'b1, 1'b0);
    clear_marks();
    repeat (15) tick(8'h3C, 3'd5, 1'b1, 1'b0);
    check_val("postrst_pulses", n_a, 1);
    check_val("postrst_edge", first_a, 6);
    repeat (10) tick(8'h3C, 3'd5, 1'b0, 1'b0);

    // Randomised traffic: held levels, single-cycle glitches, occasional reset.
    r_sw = 8'h3C; r_tst = 3'd5; ra = 1'b0; rb = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        r_sw = 8'($urandom); r_tst = 3'($urandom);
        do_reset(r_sw, r_tst, ra, rb);
      end else begin
        if ($urandom_range(0, 9) == 0) r_sw = 8'($urandom);
        if ($urandom_range(0, 11) == 0) r_tst = 3'($urandom);
        if ($urandom_range(0, 11) == 0) ra = ~ra;
        if ($urandom_range(0, 11) == 0) rb = ~rb;
        tick(($urandom_range(0, 15) == 0) ? 8'($urandom) : r_sw,
             r_tst,
             ra ^ ($urandom_range(0, 19) == 0),
             rb ^ ($urandom_range(0, 19) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
